// File: rtl/seg_nibble_scroller.sv
// Scrolls a latched multi-nibble word into a single-digit 7-seg decoder, MS nibble first,
// with a dwell and a blank gap per nibble. Optional macro SCROLL_LOOP_EN repeats the word.
module seg_nibble_scroller #(
  parameter int NIBBLES      = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 250
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [4*NIBBLES-1:0] data_i,
  output logic [4:0]           value_o,
  output logic                 blank_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int W    = 4 * NIBBLES;
  localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [IW-1:0] LAST    = IW'(NIBBLES - 1);
  localparam logic [TW-1:0] DW_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] BL_LAST = TW'(BLANK_CYCLES - 1);

  generate
    if (NIBBLES < 1 || DWELL_CYCLES < 1 || BLANK_CYCLES < 1) begin : g_bad_param
      $error("seg_nibble_scroller: NIBBLES, DWELL_CYCLES and BLANK_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [W-1:0]  shadow_q, shadow_d;
  logic [4:0]    value_d;
  logic          blank_d, busy_d, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tmr_q    <= '0;
      shadow_q <= '0;
      value_o  <= 5'h00;
      blank_o  <= 1'b1;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tmr_q    <= tmr_d;
      shadow_q <= shadow_d;
      value_o  <= value_d;
      blank_o  <= blank_d;
      busy_o   <= busy_d;
      done_o   <= done_d;
    end
  end

  // Outputs are derived from the next state so they are registered with no extra lag.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmr_d    = tmr_q + 1'b1;
    shadow_d = shadow_q;
    done_d   = 1'b0;

    if (load_i) begin
      shadow_d = data_i;
      state_d  = SHOW;
      idx_d    = LAST;
      tmr_d    = '0;
    end else begin
      case (state_q)
        IDLE: tmr_d = '0;
        SHOW: begin
          if (tmr_q == DW_LAST) begin
            state_d = GAP;
            tmr_d   = '0;
          end
        end
        GAP: begin
          if (tmr_q == BL_LAST) begin
            tmr_d = '0;
            if (idx_q != '0) begin
              state_d = SHOW;
              idx_d   = idx_q - 1'b1;
            end else begin
`ifdef SCROLL_LOOP_EN
              state_d = SHOW;
              idx_d   = LAST;
`else
              state_d = IDLE;
              done_d  = 1'b1;
`endif
            end
          end
        end
        default: begin
          state_d = IDLE;
          tmr_d   = '0;
        end
      endcase
    end

    blank_d = (state_d != SHOW);
    busy_d  = (state_d != IDLE);
    value_d = value_o;
    if (state_d == SHOW)
      value_d = {idx_d == LAST, shadow_d[{idx_d, 2'b00} +: 4]};
  end

endmodule

// File: tb/tb_seg_nibble_scroller.sv
// Randomized bench for seg_nibble_scroller against a time-since-load reference model.
module tb_seg_nibble_scroller;
  localparam int N  = 4;
  localparam int DW = 4;
  localparam int BL = 2;
  localparam int P  = DW + BL;
  localparam int L  = N * P;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_i = 1'b0;
  logic [4*N-1:0] data_i = '0;
  logic [4:0]    value_o;
  logic          blank_o, busy_o, done_o;

  seg_nibble_scroller #(.NIBBLES(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst_n(rst_n), .load_i(load_i), .data_i(data_i),
    .value_o(value_o), .blank_o(blank_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Model state: cycles elapsed since the last accepted load, and the latched word.
  bit          active = 0;
  int          since = 0;
  logic [4*N-1:0] wrd = '0;
  logic [4:0]  ev = 5'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {done,busy,blank,value} for the current cycle.
  task automatic model(output logic [7:0] e);
    logic dn, bz, bk;
    int k, n, ph;
    dn = 0; bz = 0; bk = 1;
    if (active) begin
      k = since - 1;
`ifdef SCROLL_LOOP_EN
      k = k % L;
`endif
      if (k < L) begin
        n  = k / P;
        ph = k % P;
        bz = 1;
        if (ph < DW) begin
          bk = 0;
          ev = {n == 0, wrd[4*(N-1-n) +: 4]};
        end
      end else if (k == L) begin
        dn = 1;
      end else begin
        active = 0;
      end
    end
    e = {dn, bz, bk, ev};
  endtask

  task automatic cyc(input bit ld, input logic [4*N-1:0] d);
    logic [7:0] e;
    load_i = ld;
    data_i = d;
    @(posedge clk);
    #1;
    if (ld) begin
      wrd = d; since = 1; active = 1;
    end else if (active) begin
      since++;
    end
    model(e);
    chk(ld ? "out_load" : "out", {done_o, busy_o, blank_o, value_o}, {24'h0, e});
    load_i = 0;
  endtask

  task automatic idle_rand(input int n);
    for (int i = 0; i < n; i++) cyc(0, 16'($urandom));
  endtask

  task automatic async_reset();
    #2 rst_n = 0;
    #1 chk("async_rst", {done_o, busy_o, blank_o, value_o}, {24'h0, 8'h20});
    active = 0; ev = 5'h00;
    @(posedge clk);
    #3 rst_n = 1;
  endtask

  initial begin
    #12;
    chk("reset", {done_o, busy_o, blank_o, value_o}, {24'h0, 8'h20});
    rst_n = 1;
    @(posedge clk); #1;

    idle_rand(10);

    cyc(1, 16'hA5C3); idle_rand(L + 4);
    cyc(1, 16'h1111); idle_rand(L + 4);

    // restart while the second nibble is on screen
    cyc(1, 16'h1234); idle_rand(P + 1);
    cyc(1, 16'hBEEF); idle_rand(L + 4);

    // reset during the gap after the second nibble
    cyc(1, 16'h9876); idle_rand(P + DW);
    async_reset();
    idle_rand(8);

    // load on the exact final gap cycle of a word
    cyc(1, 16'h4321); idle_rand(L - 1);
    cyc(1, 16'h00F0); idle_rand(3 * L + 5);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) cyc(1, 16'($urandom));
      else cyc(0, 16'($urandom));
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
